// File: rtl/mdp3_feed_arbiter.sv
// Packet-atomic round-robin arbiter sharing one MDP3 parser between N_CH feed channels.
// One-beat registered output stage; a watchdog releases the parser from a channel stalled mid-packet.
module mdp3_feed_arbiter #(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [64*N_CH-1:0]      in_data,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    parser_ready,
  output logic                    out_valid,
  output logic [63:0]             out_data,
  output logic                    out_last,
  output logic [$clog2(N_CH)-1:0] out_chan,
  output logic                    abort,
  output logic                    busy
);
  localparam int          CW        = $clog2(N_CH);
  localparam logic [15:0] STALL_MAX = 16'hFFFF;
  localparam logic [15:0] TMO       = 16'(TIMEOUT);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t        r_state;
  logic [CW-1:0] r_grant;
  logic [CW-1:0] r_last_grant;
  logic [15:0]   r_stall_cnt;
  logic          r_out_valid;
  logic [63:0]   r_out_data;
  logic          r_out_last;
  logic [CW-1:0] r_out_chan;
  logic          r_abort;

  logic [63:0]   w_ch_data [N_CH];
  logic [N_CH-1:0] w_in_ready;
  logic [CW:0]   w_idx;
  logic [CW-1:0] w_pick;
  logic          w_found;
  logic          w_gnt_valid;
  logic          w_gnt_last;
  logic          w_slot_free;
  logic          w_abort_now;
  logic          w_accept;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign w_ch_data[c] = in_data[64*c +: 64];
  end

  // Search starts one past the last granted channel so every requester is reached within N_CH-1 packets.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_idx = {1'b0, r_last_grant} + (CW+1)'(i);
      if (w_idx >= (CW+1)'(N_CH)) w_idx = w_idx - (CW+1)'(N_CH);
      if (!w_found && in_valid[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[CW-1:0];
      end
    end
  end

  assign w_gnt_valid = in_valid[r_grant];
  assign w_gnt_last  = in_last[r_grant];
  assign w_slot_free = !r_out_valid || parser_ready;
  assign w_abort_now = (TIMEOUT != 0) && (r_state == S_STREAM) && (r_stall_cnt == TMO);

  // No beat is taken on the abort cycle so the abandoned channel cannot slip one more beat in.
  always_comb begin
    w_in_ready = '0;
    if (r_state == S_STREAM && !w_abort_now) w_in_ready[r_grant] = w_slot_free;
  end

  assign w_accept = w_gnt_valid && w_in_ready[r_grant];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= CW'(N_CH-1);
      r_stall_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_chan   <= '0;
      r_abort      <= 1'b0;
    end else begin
      r_abort <= 1'b0;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[r_grant];
        r_out_last  <= w_gnt_last;
        r_out_chan  <= r_grant;
      end else if (parser_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_pick;
            r_stall_cnt <= '0;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_abort_now) begin
            r_abort      <= 1'b1;
            r_last_grant <= r_grant;
            r_stall_cnt  <= '0;
            r_state      <= S_IDLE;
          end else if (w_accept) begin
            r_stall_cnt <= '0;
            if (w_gnt_last) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end
          end else if (!w_gnt_valid && r_stall_cnt != STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_chan  = r_out_chan;
  assign abort     = r_abort;
  assign busy      = (r_state == S_STREAM) || r_out_valid;

endmodule
